// File: rtl/palette_pkg.sv
// Shared types and constants for the palette bank fader: fade FSM states,
// brightness range and the palette every bank loads at reset.
package palette_pkg;

  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = 5;

  typedef enum logic [1:0] {IDLE, FADE_OUT, DARK, FADE_IN} fade_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Leftmost element is entry 0; each entry is {R,G,B}.
  localparam logic [0:15][11:0] DEFAULT_PALETTE = {
    12'h000, 12'hEA8, 12'h444, 12'h000, 12'hF00, 12'hC86, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'hF0F, 12'h888, 12'hFFF, 12'h731, 12'h5A2, 12'h29D
  };

  function automatic logic [11:0] default_entry(input logic [3:0] idx);
    return DEFAULT_PALETTE[idx];
  endfunction

endpackage

// File: rtl/palette_bank_fader_fade_ctrl.sv
// Frame-synchronous fade engine: IDLE/FADE_OUT/DARK/FADE_IN FSM, frame step
// counter and the 0..16 brightness level sampled by the pixel pipeline.
module fade_ctrl
  import palette_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_start_i,
  input  logic               fade_out_req_i,
  input  logic               fade_in_req_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               fade_busy_o,
  output logic               wr_ready_o
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(LEVEL_MAX);

  fade_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      level_q <= LVL_FULL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    step_s  = 1'b0;
    // Frames are only counted while actively fading.
    if ((state_q == FADE_OUT || state_q == FADE_IN) && frame_start_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_s = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (fade_out_req_i) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FADE_OUT: begin
        if (step_s) begin
          level_d = level_q - 5'd1;
          state_d = (level_q == 5'd1) ? DARK : FADE_OUT;
        end else begin
          state_d = FADE_OUT;
        end
      end
      DARK: begin
        if (fade_in_req_i) begin
          state_d = FADE_IN;
          cnt_d   = '0;
        end else begin
          state_d = DARK;
        end
      end
      FADE_IN: begin
        if (step_s) begin
          level_d = level_q + 5'd1;
          state_d = (level_q == LVL_FULL - 5'd1) ? IDLE : FADE_IN;
        end else begin
          state_d = FADE_IN;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = LVL_FULL;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o     = level_q;
  assign fade_busy_o = (state_q == FADE_OUT) || (state_q == FADE_IN);
  assign wr_ready_o  = !((state_q == FADE_OUT) || (state_q == FADE_IN));

endmodule

// File: rtl/palette_bank_fader.sv
// Runtime-writable multi-bank colour lookup with a 2-stage pipeline:
// stage 1 reads the raw entry, stage 2 scales it by the fade level.
module palette_bank_fader
  import palette_pkg::*;
#(
  parameter int INDEX_W         = 4,
  parameter int COLOR_W         = 4,
  parameter int BANKS           = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int TRANSPARENT_IDX = 0,
  localparam int BANK_W         = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int RGB_W          = 3 * COLOR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pix_valid,
  input  logic [BANK_W-1:0]  bank,
  input  logic [INDEX_W-1:0] index,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [RGB_W-1:0]   wr_rgb,
  output logic               wr_ready,
  input  logic               fade_out_req,
  input  logic               fade_in_req,
  output logic               fade_busy,
  output logic               out_valid,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               transparent
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int PROD_W  = COLOR_W + LEVEL_W;

  logic [RGB_W-1:0]   mem_q [BANKS][ENTRIES];
  logic [RGB_W-1:0]   rd_q;
  logic               trans1_q, vld1_q;
  logic               out_valid_q, transparent_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic [LEVEL_W-1:0] level_s;
  logic               wr_ready_s;

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [LEVEL_W-1:0] lvl);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(lvl);
    return p[COLOR_W+3:4];
  endfunction

  fade_ctrl #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_fade (
    .clk_i         (Clk),
    .rst_i         (Reset),
    .frame_start_i (frame_start),
    .fade_out_req_i(fade_out_req),
    .fade_in_req_i (fade_in_req),
    .level_o       (level_s),
    .fade_busy_o   (fade_busy),
    .wr_ready_o    (wr_ready_s)
  );

  // Palette storage; reset reloads every bank with the default palette.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem_q[b][e] <= RGB_W'(default_entry(4'(e)));
        end
      end
    end else if (wr_en && wr_ready_s) begin
      mem_q[wr_bank][wr_index] <= wr_rgb;
    end
  end

  // Stage 1 reads the pre-write contents, so a same-cycle collision sees old data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_q     <= '0;
      trans1_q <= 1'b0;
      vld1_q   <= 1'b0;
    end else begin
      rd_q     <= mem_q[bank][index];
      trans1_q <= (index == INDEX_W'(TRANSPARENT_IDX));
      vld1_q   <= pix_valid;
    end
  end

  // Stage 2 applies the current level; colour holds when no pixel arrives.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_q   <= 1'b0;
      transparent_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      out_valid_q   <= vld1_q;
      transparent_q <= trans1_q;
      if (vld1_q) begin
        red_q   <= scale(rd_q[3*COLOR_W-1 -: COLOR_W], level_s);
        green_q <= scale(rd_q[2*COLOR_W-1 -: COLOR_W], level_s);
        blue_q  <= scale(rd_q[COLOR_W-1:0], level_s);
      end
    end
  end

  assign wr_ready    = wr_ready_s;
  assign out_valid   = out_valid_q;
  assign transparent = transparent_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_palette_bank_fader.sv
// Directed bench for palette_bank_fader: a scoreboard queue of expected
// pixels is filled as lookups are driven and drained as outputs appear.
module tb_palette_bank_fader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [1:0]  bank = 2'd0;
  logic [3:0]  index = 4'd0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = 2'd0;
  logic [3:0]  wr_index = 4'd0;
  logic [11:0] wr_rgb = 12'h000;
  logic        wr_ready;
  logic        fade_out_req = 1'b0;
  logic        fade_in_req = 1'b0;
  logic        fade_busy;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;

  palette_bank_fader #(
    .INDEX_W(4), .COLOR_W(4), .BANKS(4), .FRAMES_PER_STEP(1), .TRANSPARENT_IDX(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .bank(bank), .index(index),
    .frame_start(frame_start), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_rgb(wr_rgb), .wr_ready(wr_ready), .fade_out_req(fade_out_req),
    .fade_in_req(fade_in_req), .fade_busy(fade_busy), .out_valid(out_valid),
    .red(red), .green(green), .blue(blue), .transparent(transparent)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    int          id;
    logic [11:0] rgb;
    logic        t;
  } exp_t;

  localparam logic [11:0] TB_DEF [16] = '{
    12'h000, 12'hEA8, 12'h444, 12'h000, 12'hF00, 12'hC86, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'hF0F, 12'h888, 12'hFFF, 12'h731, 12'h5A2, 12'h29D
  };

  logic [11:0] pal [4][16];
  exp_t        sb [$];
  exp_t        e;
  int          cyc = 0;
  int          lvl = 16;
  int          n_id = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [11:0] faded(input logic [11:0] c, input int l);
    int r, g, b;
    r = (int'(c[11:8]) * l) / 16;
    g = (int'(c[7:4]) * l) / 16;
    b = (int'(c[3:0]) * l) / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++) pal[b][i] = TB_DEF[i];
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: pop a due pixel, otherwise out_valid must be low.
  always @(negedge Clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_vec++;
      assert ({out_valid, transparent, red, green, blue} === {1'b1, e.t, e.rgb}) else begin
        n_err++;
        $error("FAIL lookup_%0d observed v=%b t=%b rgb=%h expected v=1 t=%b rgb=%h",
               e.id, out_valid, transparent, {red, green, blue}, e.t, e.rgb);
      end
    end else begin
      n_vec++;
      assert (out_valid === 1'b0) else begin
        n_err++;
        $error("FAIL idle_valid observed %b expected 0 at cycle %0d", out_valid, cyc);
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    pix_valid    = 1'b0;
    frame_start  = 1'b0;
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
  endtask

  task automatic look(input int b, input int i);
    exp_t x;
    pix_valid = 1'b1;
    bank      = 2'(b);
    index     = 4'(i);
    x.due = cyc + 2;
    x.id  = n_id++;
    x.rgb = faded(pal[b][i], lvl);
    x.t   = (i == 0);
    sb.push_back(x);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      frame_start = 1'b1;
      tick();
    end
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_out", {out_valid, transparent, red, green, blue}, 16'h0000);
    chk("rst_busy", {15'd0, fade_busy}, 16'd0);
    chk("rst_ready", {15'd0, wr_ready}, 16'd1);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Default palette, transparency and back-to-back throughput.
    tick(); look(2, 1);
    tick(); look(2, 0);
    tick(); look(3, 15);
    drain();

    // Write collision: same-cycle read sees old data, next read sees new.
    tick();
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd5; wr_rgb = 12'h3CF;
    chk("wr_ready_idle", {15'd0, wr_ready}, 16'd1);
    look(1, 5);
    pal[1][5] = 12'h3CF;
    tick(); wr_en = 1'b0;
    look(1, 5);
    tick(); look(0, 5);
    drain();

    // fade_in_req in IDLE is ignored.
    tick(); fade_in_req = 1'b1;
    tick();
    chk("ign_busy", {15'd0, fade_busy}, 16'd0);
    frames(2);
    look(2, 1);
    drain();

    // Both requests plus frame_start in IDLE: fade out starts, frame not counted.
    tick(); fade_out_req = 1'b1; fade_in_req = 1'b1; frame_start = 1'b1;
    tick();
    chk("fo_busy", {15'd0, fade_busy}, 16'd1);
    chk("fo_ready", {15'd0, wr_ready}, 16'd0);
    frames(8);
    lvl = 8;
    look(2, 1);
    drain();
    frames(8);
    lvl = 0;
    chk("dark_busy", {15'd0, fade_busy}, 16'd0);
    chk("dark_ready", {15'd0, wr_ready}, 16'd1);
    look(2, 1);
    tick(); look(0, 12);
    drain();

    // Fade in with a write held: dropped while fading, accepted once IDLE.
    tick(); fade_in_req = 1'b1;
    tick();
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd7; wr_rgb = 12'h123;
    chk("fi_ready", {15'd0, wr_ready}, 16'd0);
    chk("fi_busy", {15'd0, fade_busy}, 16'd1);
    frames(4);
    lvl = 4;
    look(1, 7);
    tick(); look(1, 5);
    drain();
    frames(12);
    lvl = 16;
    chk("fi_done_ready", {15'd0, wr_ready}, 16'd1);
    chk("fi_done_busy", {15'd0, fade_busy}, 16'd0);
    tick(); wr_en = 1'b0;
    pal[1][7] = 12'h123;
    look(1, 7);
    drain();

    // Reset mid-fade with a pixel in flight.
    tick(); fade_out_req = 1'b1;
    tick();
    frames(11);
    lvl = 5;
    look(2, 1);
    drain();
    tick(); look(1, 5);
    tick();
    @(posedge Clk); #2;
    chk("inflight_valid", {15'd0, out_valid}, 16'd1);
    sb.delete();
    Reset = 1'b1;
    #1;
    chk("amid_valid", {15'd0, out_valid}, 16'd0);
    chk("amid_busy", {15'd0, fade_busy}, 16'd0);
    chk("amid_ready", {15'd0, wr_ready}, 16'd1);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    lvl = 16;
    tick(); look(1, 5);
    tick(); look(1, 7);
    tick(); look(2, 0);
    drain();
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/palette_bank_fader.md
# palette_bank_fader

Parametrised, runtime-writable colour lookup for the VGA pixel path. It holds `BANKS` independent palettes of 2^`INDEX_W` entries each, with writes accepted through a ready/enable handshake. A frame-synchronous fade engine scales output brightness between full and black. It sits between the sprite/background index mux and the VGA controller's RGB inputs, with a fixed 2-cycle latency.

## Interface

**Parameters**
- `INDEX_W`, 4: palette index width; 2^`INDEX_W` entries per bank.
- `COLOR_W`, 4: bits per colour channel.
- `BANKS`, 4: number of palette banks; `BANK_W` = $clog2(`BANKS`).
- `FRAMES_PER_STEP`, 2: `frame_start` pulses per fade level step; must be ≥1.
- `TRANSPARENT_IDX`, 0: index flagged as transparent.

**Ports**
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high.
- `pix_valid` in 1: lookup request this cycle.
- `bank` in `BANK_W`: bank select for the lookup.
- `index` in `INDEX_W`: colour index for the lookup.
- `frame_start` in 1: one-cycle pulse per frame (vsync edge).
- `wr_en` in 1: palette write request.
- `wr_bank` in `BANK_W`: target bank.
- `wr_index` in `INDEX_W`: target entry.
- `wr_rgb` in 3*`COLOR_W`: {R,G,B} to store.
- `wr_ready` out 1: write accepted when `wr_en` && `wr_ready`.
- `fade_out_req` in 1: pulse; starts fade to black.
- `fade_in_req` in 1: pulse; starts fade to full.
- `fade_busy` out 1: fade in progress.
- `out_valid` out 1: RGB valid.
- `red`, `green`, `blue` out `COLOR_W` each: scaled colour.
- `transparent` out 1: looked-up index equalled `TRANSPARENT_IDX`.

## Operation

- **Storage:** `BANKS` × 2^`INDEX_W` × 3*`COLOR_W` register file.
  - On `Reset`, every bank loads `DEFAULT_PALETTE` from the package. Entry 1 is {E,A,8}; entry 3 is {0,0,0}.
- **Write:** an accepted write updates the entry at the clock edge.
  - `wr_ready` = 1 in IDLE and DARK, 0 in FADE_OUT and FADE_IN.
  - Writes presented while `wr_ready`=0 are dropped; the writer must hold the request.
- **Lookup stage 1:** registers the raw entry, `index`==`TRANSPARENT_IDX`, and `pix_valid`.
  - Read-during-write to the same entry returns the old value.
- **Lookup stage 2:** each channel becomes (c × `level`) >> 4.
  - `level` is 5 bits, range 0..16; level 16 is identity.
  - The product is `COLOR_W`+5 bits wide; the result is truncated to `COLOR_W`.
  - `transparent` and `out_valid` pass through unchanged.
  - When `out_valid`=0, the RGB outputs hold their previous value.
- **Fade FSM:**
  - IDLE (`level`=16): `fade_out_req` → FADE_OUT.
  - FADE_OUT: on each `FRAMES_PER_STEP`-th `frame_start`, `level` -= 1. When it reaches 0 → DARK.
  - DARK (`level`=0): `fade_in_req` → FADE_IN.
  - FADE_IN: `level` += 1 per step. When it reaches 16 → IDLE.
  - Requests in any other state are ignored.
  - If both requests arrive together in IDLE or DARK, only the one valid for that state acts.
- **Step counter:**
  - Cleared when the FSM enters FADE_OUT or FADE_IN.
  - Counts only in those two states.
  - Wraps at `FRAMES_PER_STEP`.
- `fade_busy` = (state == FADE_OUT || state == FADE_IN).

## Timing

- Lookup latency is 2 cycles: a request at edge N produces `out_valid` and RGB after edge N+2. Throughput is 1 lookup per cycle.
- `level` is sampled by stage 2, so a level change affects pixels already in flight.
- A fade request is registered at edge N; state changes at that edge, and `wr_ready` drops combinationally from state in the cycle after N.
- **Reset values:**
  - `out_valid`=0, RGB=0, `transparent`=0.
  - `level`=16, state IDLE, `fade_busy`=0, `wr_ready`=1.
  - Palette contents = `DEFAULT_PALETTE`.
- `Reset` asserted mid-fade or mid-write aborts immediately: no partial entry, and the pipeline is flushed.
- Simultaneous `frame_start` and a fade request in IDLE or DARK: the transition occurs, and that `frame_start` is not counted.

## Structure

- **Package `palette_pkg`:**
  - `DEFAULT_PALETTE` constant, [0:15][11:0].
  - `fade_state_t` enum {IDLE, FADE_OUT, DARK, FADE_IN}.
  - `LEVEL_MAX` = 16.
  - `rgb_t` struct.
- **Sub-module `fade_ctrl`:** contains the FSM, step counter and `level` register. Outputs `level`, `fade_busy` and `wr_ready`.
- The top level holds the register file and the two pipeline stages.

## Test plan

- **Reset default:** release reset, then lookup bank 2 index 1 → 2 cycles later `out_valid`=1, RGB = E,A,8, `transparent`=0. Index 0 gives `transparent`=1.
- **Write then read, with collision:**
  - Write bank 1 idx 5 = {3,C,F}.
  - Lookup of the same entry in the same cycle returns `DEFAULT_PALETTE`[5] = {C,8,6}.
  - Lookup one cycle later returns 3,C,F.
- **Fade out, `FRAMES_PER_STEP`=1:**
  - `fade_out_req`, then 8 `frame_start` pulses → `level`=8; index 1 gives 7,5,4.
  - After 16 pulses: state DARK, RGB 0,0,0, `fade_busy`=0.
- **Write blocked during fade:** `wr_en` held during FADE_IN → `wr_ready`=0 and entry unchanged. After `level` returns to 16, the write is accepted.
- **Ignored / simultaneous requests:**
  - `fade_in_req` in IDLE → no change.
  - Both requests together in IDLE → FADE_OUT.
- **Reset mid-fade:** at `level`=5 in FADE_OUT, assert `Reset` asynchronously → `level`=16, IDLE, `out_valid`=0, palette restored.
